// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch-side branch predictor.
// Holds the 2-bit predictor counter encoding, the table entry layout and the default table size.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Default number of direct-mapped predictor entries.
    localparam int BTB_ENTRIES_DEF = 16;

    // Tag field is sized for the smallest legal table (4 entries -> 28 tag bits);
    // larger tables store their shorter tag zero-extended into this field.
    localparam int BP_TAG_W = 28;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,   // strong not-taken
        CNT_WNT = 2'b01,   // weak not-taken
        CNT_WT  = 2'b10,   // weak taken
        CNT_ST  = 2'b11    // strong taken
    } bp_cnt_e;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [29:0]         target;   // word-aligned target, PC[31:2]
        bp_cnt_e             cnt;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_RST = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        cnt:    CNT_WNT
    };

    // Upper counter bit is the taken/not-taken prediction.
    function automatic logic cnt_predicts_taken(input bp_cnt_e c);
        return c[1];
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle between the PC logic and the branch predictor.
// Ports: imemaddr (current fetch PC), psel (predict taken), pPC (predicted next PC).
// Purely combinational signals; no handshake, the predictor answers in the same cycle.
interface fetch_if;
    import cpu_types_pkg::*;

    word_t imemaddr;
    logic  psel;
    word_t pPC;

    // Predictor side: consumes the fetch PC, produces the prediction.
    modport bp (
        input  imemaddr,
        output psel,
        output pPC
    );

    // Fetch side: drives the PC, consumes the prediction.
    modport fetch (
        output imemaddr,
        input  psel,
        input  pPC
    );

endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state: +1 on taken, -1 on not-taken, clamped at 11 / 00.
// Latency: combinational, zero cycles.
// Backpressure: none; ports cnt_i (current), taken_i (outcome), cnt_o (next value).
module sat_counter2
    import cpu_types_pkg::*;
(
    input  bp_cnt_e cnt_i,
    input  logic    taken_i,
    output bp_cnt_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_ST) begin
                cnt_o = bp_cnt_e'(cnt_i + 2'd1);
            end
        end else begin
            if (cnt_i != CNT_SNT) begin
                cnt_o = bp_cnt_e'(cnt_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, trained from the EX stage.
// Latency: lookup is combinational (zero cycles); updates become visible the cycle after the edge.
// Backpressure: none; updates are accepted every cycle regardless of fetch stalls.
// Ports: CLK, nRST (async active-low), fif (fetch_if.bp: imemaddr in, psel/pPC out),
//        update_en/update_pc/update_taken/update_target (resolved branch), flush (clear valid bits).
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic  CLK,
    input  logic  nRST,
    fetch_if.bp   fif,
    input  logic  update_en,
    input  word_t update_pc,
    input  logic  update_taken,
    input  word_t update_target,
    input  logic  flush
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t entries_q [BTB_ENTRIES];
    btb_entry_t entries_d [BTB_ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX-1:0]      l_idx;
    logic [BP_TAG_W-1:0] l_tag;
    btb_entry_t          l_entry;
    logic                l_hit;

    assign l_idx   = fif.imemaddr[IDX+1:2];
    assign l_tag   = BP_TAG_W'(fif.imemaddr[31:IDX+2]);
    assign l_entry = entries_q[l_idx];
    assign l_hit   = l_entry.valid && (l_entry.tag == l_tag);

    // Reads the registered table only, so a same-cycle update is not bypassed.
    assign fif.psel = l_hit && cnt_predicts_taken(l_entry.cnt);
    assign fif.pPC  = l_hit ? {l_entry.target, 2'b00} : (fif.imemaddr + 32'd4);

    // ---------------- update ----------------
    logic [IDX-1:0]      u_idx;
    logic [BP_TAG_W-1:0] u_tag;
    logic                u_hit;
    bp_cnt_e             u_cnt_next;

    assign u_idx = update_pc[IDX+1:2];
    assign u_tag = BP_TAG_W'(update_pc[31:IDX+2]);
    assign u_hit = entries_q[u_idx].valid && (entries_q[u_idx].tag == u_tag);

    sat_counter2 u_sat_counter2 (
        .cnt_i   (entries_q[u_idx].cnt),
        .taken_i (update_taken),
        .cnt_o   (u_cnt_next)
    );

    // Byte-offset bits of the update PC/target carry no information for word-aligned fetch.
    logic unused_lsbs;
    assign unused_lsbs = ^{update_pc[1:0], update_target[1:0]};

    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            // Flush takes priority over a coincident update: nothing is allocated.
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end else if (update_en) begin
            if (u_hit) begin
                entries_d[u_idx].cnt = u_cnt_next;
                if (update_taken) begin
                    entries_d[u_idx].target = update_target[31:2];
                end
            end else if (update_taken) begin
                // Miss on a taken branch replaces whatever aliased into this slot.
                entries_d[u_idx] = '{
                    valid:  1'b1,
                    tag:    u_tag,
                    target: update_target[31:2],
                    cnt:    CNT_WT
                };
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entries_q <= '{default: BTB_ENTRY_RST};
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;
    logic  update_en;
    word_t update_pc;
    logic  update_taken;
    word_t update_target;
    logic  flush;

    int total;
    int bad;

    fetch_if fif ();

    branch_predictor #(.BTB_ENTRIES(16)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .fif           (fif),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .flush         (flush)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle update pulse; returns 2 units after the edge with the table updated.
    task automatic upd(input word_t pc, input logic tk, input word_t tgt);
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        update_en     = 1'b1;
        step();
        update_en = 1'b0;
        #1;
    endtask

    task automatic look(input word_t a);
        fif.imemaddr = a;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        look(32'h0000_0040);
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL reset_psel got=%0b want=0", fif.psel); end
        total++; if (fif.pPC !== 32'h0000_0044) begin bad++; $display("FAIL reset_ppc got=%h want=00000044", fif.pPC); end
        look(32'hFFFF_FFFC);
        total++; if (fif.pPC !== 32'h0000_0000) begin bad++; $display("FAIL wrap_ppc got=%h want=00000000", fif.pPC); end
        step();
        step();
        #2 nRST = 1'b1;
        step();
        look(32'h0000_0040);
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL post_reset_psel got=%0b want=0", fif.psel); end
    endtask

    task automatic test_basic();
        upd(32'h40, 1'b1, 32'h100);            // allocate, counter 10
        look(32'h40);
        total++; if (fif.psel !== 1'b1) begin bad++; $display("FAIL alloc_psel got=%0b want=1", fif.psel); end
        total++; if (fif.pPC !== 32'h100) begin bad++; $display("FAIL alloc_ppc got=%h want=00000100", fif.pPC); end
        upd(32'h40, 1'b0, 32'h0);              // 01
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL wnt_psel got=%0b want=0", fif.psel); end
        upd(32'h40, 1'b0, 32'h0);              // 00
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL snt_psel got=%0b want=0", fif.psel); end
        total++; if (fif.pPC !== 32'h100) begin bad++; $display("FAIL snt_hit_ppc got=%h want=00000100", fif.pPC); end
        upd(32'h40, 1'b1, 32'h100);            // 01
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL back_wnt_psel got=%0b want=0", fif.psel); end
    endtask

    task automatic test_saturation();
        // counter is 01: go 10, 11, 11, 11
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);              // 10
        total++; if (fif.psel !== 1'b1) begin bad++; $display("FAIL sat_hi_psel got=%0b want=1", fif.psel); end
        upd(32'h40, 1'b0, 32'h0);              // 01
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL sat_hi_dn_psel got=%0b want=0", fif.psel); end
        upd(32'h40, 1'b0, 32'h0);              // 00
        upd(32'h40, 1'b0, 32'h0);              // stays 00
        upd(32'h40, 1'b1, 32'h100);            // 01
        upd(32'h40, 1'b1, 32'h100);            // 10
        total++; if (fif.psel !== 1'b1) begin bad++; $display("FAIL sat_lo_psel got=%0b want=1", fif.psel); end
        // Taken hit rewrites target; low address bits ignored.
        upd(32'h43, 1'b1, 32'h183);
        total++; if (fif.pPC !== 32'h180) begin bad++; $display("FAIL retarget_ppc got=%h want=00000180", fif.pPC); end
    endtask

    task automatic test_alias();
        look(32'h80);
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL alias_miss_psel got=%0b want=0", fif.psel); end
        total++; if (fif.pPC !== 32'h84) begin bad++; $display("FAIL alias_miss_ppc got=%h want=00000084", fif.pPC); end
        upd(32'h80, 1'b1, 32'h200);
        total++; if (fif.psel !== 1'b1) begin bad++; $display("FAIL alias_hit_psel got=%0b want=1", fif.psel); end
        total++; if (fif.pPC !== 32'h200) begin bad++; $display("FAIL alias_hit_ppc got=%h want=00000200", fif.pPC); end
        look(32'h40);
        total++; if (fif.pPC !== 32'h44) begin bad++; $display("FAIL evicted_ppc got=%h want=00000044", fif.pPC); end
        upd(32'h40, 1'b0, 32'h300);            // miss, not taken: no change
        total++; if (fif.pPC !== 32'h44) begin bad++; $display("FAIL nt_miss_ppc got=%h want=00000044", fif.pPC); end
        look(32'h80);
        total++; if (fif.pPC !== 32'h200) begin bad++; $display("FAIL nt_miss_keep_ppc got=%h want=00000200", fif.pPC); end
    endtask

    task automatic test_same_cycle_and_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        look(32'h80);
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL flush_psel got=%0b want=0", fif.psel); end
        total++; if (fif.pPC !== 32'h84) begin bad++; $display("FAIL flush_ppc got=%h want=00000084", fif.pPC); end
        look(32'h40);
        update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h100; update_en = 1'b1;
        #1;
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL same_cycle_psel got=%0b want=0", fif.psel); end
        step();
        update_en = 1'b0;
        #1;
        total++; if (fif.psel !== 1'b1) begin bad++; $display("FAIL next_cycle_psel got=%0b want=1", fif.psel); end
        // flush wins over a coincident allocation
        update_pc = 32'h44; update_taken = 1'b1; update_target = 32'h500; update_en = 1'b1; flush = 1'b1;
        step();
        update_en = 1'b0; flush = 1'b0;
        look(32'h44);
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL flush_upd_psel got=%0b want=0", fif.psel); end
        total++; if (fif.pPC !== 32'h48) begin bad++; $display("FAIL flush_upd_ppc got=%h want=00000048", fif.pPC); end
        look(32'h40);
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL flush_upd_old_psel got=%0b want=0", fif.psel); end
    endtask

    task automatic test_async_reset();
        upd(32'h40, 1'b1, 32'h100);
        total++; if (fif.psel !== 1'b1) begin bad++; $display("FAIL pre_arst_psel got=%0b want=1", fif.psel); end
        nRST = 1'b0;                           // between edges
        #1;
        total++; if (fif.psel !== 1'b0) begin bad++; $display("FAIL arst_psel got=%0b want=0", fif.psel); end
        total++; if (fif.pPC !== 32'h44) begin bad++; $display("FAIL arst_ppc got=%h want=00000044", fif.pPC); end
        // update attempted while reset held is discarded
        update_pc = 32'h80; update_taken = 1'b1; update_target = 32'h200; update_en = 1'b1;
        step();
        update_en = 1'b0;
        #2 nRST = 1'b1;
        step();
        look(32'h80);
        total++; if (fif.pPC !== 32'h84) begin bad++; $display("FAIL arst_upd_ppc got=%h want=00000084", fif.pPC); end
        look(32'h40);
        total++; if (fif.pPC !== 32'h44) begin bad++; $display("FAIL arst_after_ppc got=%h want=00000044", fif.pPC); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        update_en = 1'b0;
        update_pc = '0;
        update_taken = 1'b0;
        update_target = '0;
        flush = 1'b0;
        fif.imemaddr = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_alias();
        test_same_cycle_and_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
